spr_bist: RTL and testbench
===========================

Name: spr_bist

Overview:
- March C- built-in self-test initiator for the 64x8 single-port RAM.
- Acts as the requester side of the RAM port: it drives din, we, rd and addr, and samples dout.
- On a start pulse it runs six march elements, compares every read against the expected pattern, and reports pass/fail together with the first failing location.
- Sits between the test/config logic and the RAM, muxed ahead of the functional port (the mux is external).

Parameters:
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- RD_LATENCY, 1, cycles from rd sampled high to dout valid (1..3).
- BG, 8'h00, data background. Its complement ~BG is the "1" pattern.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- busy  out  1  high while a run is in progress.
- done  out  1  high from end of run until next start.
- fail  out  1  valid while done; 1 = mismatch detected.
- fail_addr  out  ADDR_W  address of first mismatch.
- fail_data  out  DATA_W  dout value captured at first mismatch.
- fail_elem  out  3  march element index (1..5) of first mismatch.
- we  out  1  RAM write enable.
- rd  out  1  RAM read enable.
- addr  out  ADDR_W  RAM address.
- din  out  DATA_W  RAM write data.
- dout  in  DATA_W  RAM read data.

Behaviour:
- Reset: busy, done, fail, we and rd are 0; addr, din, fail_addr, fail_data and fail_elem are 0. FSM goes to IDLE.
- Reset asserted mid-run aborts immediately. No further RAM accesses occur and no result is retained.
- FSM states: IDLE, E0..E5, DONE.
- start sampled high in IDLE or DONE: clear done/fail/fail_*, then go to E0 with busy=1. The first RAM access occurs in the following cycle.
- start is ignored while busy.
- Elements, where A = ascending 0..63 and D = descending 63..0:
  - E0: A write BG.
  - E1: A read BG, write ~BG.
  - E2: A read ~BG, write BG.
  - E3: D read BG, write ~BG.
  - E4: D read ~BG, write BG.
  - E5: A read BG.
- Write-only element: one cycle per address, with we=1 and din=pattern.
- Read-write element, per address:
  - cycle 0: rd=1.
  - RD_LATENCY-1 wait cycles: we=rd=0.
  - final cycle: dout is compared at the closing edge, and we=1 with the new pattern is issued in the same cycle.
  - Total: RD_LATENCY+1 cycles per address.
- Read-only element (E5): identical to a read-write element except we=0 in the compare cycle.
- Never assert we and rd together.
- addr is held constant across all cycles of one address step.
- The address counter wraps 63->0 only at element boundaries. Element change happens at the last address: 63 for A, 0 for D.
- Mismatch (dout != expected):
  - Capture fail_addr, fail_data and fail_elem.
  - The write already issued in that cycle completes.
  - Next cycle: go to DONE with we=rd=0, busy=0, done=1, fail=1.
- No mismatch: after the last compare of E5, go to DONE with done=1, fail=0.
- Run length with RD_LATENCY=1 is 64 + 5*128 = 704 cycles of busy. In general it is 64*(1 + 5*(RD_LATENCY+1)).
- In IDLE and DONE: we=rd=0. addr and din hold their last values.
- All outputs are registered.

Decomposition:
- Package spr_pkg holds:
  - ADDR_W and DATA_W constants.
  - A march_elem_e enum (E0..E5).
  - A per-element table giving direction, read-expected pattern select and write pattern select (none/BG/~BG).
- One sub-module, spr_bist_addr_gen:
  - up/down counter with load-to-start (0 or 63);
  - step enable;
  - last-address flag.

Test Plan:
- Clean RAM model, RD_LATENCY=1, BG=8'h00, start at cycle 0 -> busy high exactly 704 cycles, then done=1, fail=0. E0 writes 8'h00 to addr 0..63; E3 first access is rd at addr 63.
- Stuck-at-1 on bit 3 of addr 0x2A -> fail=1, fail_elem=1, fail_addr=6'h2A, fail_data=8'h08. No RAM access after the failing cycle.
- Coupling fault (write of addr 0x10 flips bit 0 of addr 0x11) -> fail=1, fail_elem=1, fail_addr=6'h11, fail_data=8'h01.
- RD_LATENCY=3, BG=8'h55, clean RAM -> busy high 1344 cycles, fail=0. Every RAM cycle is checked to have we&rd=0.
- start pulsed again at cycle 300 of a run -> ignored, and the run still ends at cycle 704. A start while done=1 clears done and reruns.
- rst low at cycle 400 -> we, rd, busy, done and fail are 0 asynchronously. After release the FSM is in IDLE with no RAM access until start.

Source files
------------

// File: rtl/spr_pkg.sv
// Shared constants and the March C- element table for the single-port RAM self-test.
// Each element lists its direction, the pattern it reads back and the pattern it writes.
package spr_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        E0,
        E1,
        E2,
        E3,
        E4,
        E5
    } march_elem_e;

    typedef enum logic [1:0] {
        PAT_NONE,
        PAT_BG,
        PAT_INV
    } pat_sel_e;

    typedef struct packed {
        logic     desc;
        pat_sel_e rd_pat;
        pat_sel_e wr_pat;
    } elem_cfg_t;

    // rd_pat of PAT_NONE marks the write-only element.
    localparam elem_cfg_t ELEM_TABLE [6] = '{
        '{desc: 1'b0, rd_pat: PAT_NONE, wr_pat: PAT_BG  },
        '{desc: 1'b0, rd_pat: PAT_BG,   wr_pat: PAT_INV },
        '{desc: 1'b0, rd_pat: PAT_INV,  wr_pat: PAT_BG  },
        '{desc: 1'b1, rd_pat: PAT_BG,   wr_pat: PAT_INV },
        '{desc: 1'b1, rd_pat: PAT_INV,  wr_pat: PAT_BG  },
        '{desc: 1'b0, rd_pat: PAT_BG,   wr_pat: PAT_NONE}
    };

endpackage

// File: rtl/spr_bist_addr_gen.sv
// Up/down address counter for the march: loads the element start address (0 or top),
// steps once per address and flags the last address in the current direction.
module spr_bist_addr_gen #(
    parameter int ADDR_W = spr_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_load_desc,
    input  logic              i_step,
    input  logic              i_desc,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_desc ? TOP_ADDR : '0;
        end else if (i_step) begin
            r_addr <= i_desc ? r_addr - 1'b1 : r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = i_desc ? (r_addr == '0) : (r_addr == TOP_ADDR);

endmodule

// File: rtl/spr_bist.sv
// March C- self-test initiator for the single-port RAM: drives the RAM port, checks
// every read against the expected background and records the first failing location.
module spr_bist #(
    parameter int               ADDR_W     = spr_pkg::ADDR_W,
    parameter int               DATA_W     = spr_pkg::DATA_W,
    parameter int               RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] BG        = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [2:0]        fail_elem,
    output logic              we,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout
);

    import spr_pkg::*;

    typedef enum logic [3:0] {
        S_IDLE,
        S_E0,
        S_E1,
        S_E2,
        S_E3,
        S_E4,
        S_E5,
        S_DONE
    } state_e;

    localparam logic [1:0] LAST_PH = 2'(RD_LATENCY);

    function automatic march_elem_e elem_of(input state_e s);
        case (s)
            S_E1:    elem_of = E1;
            S_E2:    elem_of = E2;
            S_E3:    elem_of = E3;
            S_E4:    elem_of = E4;
            S_E5:    elem_of = E5;
            default: elem_of = E0;
        endcase
    endfunction

    function automatic state_e next_state(input state_e s);
        case (s)
            S_E0:    next_state = S_E1;
            S_E1:    next_state = S_E2;
            S_E2:    next_state = S_E3;
            S_E3:    next_state = S_E4;
            S_E4:    next_state = S_E5;
            default: next_state = S_DONE;
        endcase
    endfunction

    state_e            r_state;
    logic [1:0]        r_phase;

    march_elem_e       w_elem;
    march_elem_e       w_next_elem;
    elem_cfg_t         w_cfg;
    logic              w_run;
    logic              w_wr_only;
    logic              w_final;
    logic              w_step_end;
    logic              w_mismatch;
    logic              w_last;
    logic              w_load;
    logic              w_load_desc;
    logic              w_step;
    logic [DATA_W-1:0] w_exp;
    logic [DATA_W-1:0] w_wr_data;
    logic [ADDR_W-1:0] w_addr;

    assign w_elem      = elem_of(r_state);
    assign w_next_elem = elem_of(next_state(r_state));
    assign w_cfg       = ELEM_TABLE[w_elem];
    assign w_run       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_wr_only   = (r_state == S_E0);
    assign w_final     = (r_phase == LAST_PH);
    assign w_step_end  = w_wr_only || w_final;
    assign w_exp       = (w_cfg.rd_pat == PAT_INV) ? ~BG : BG;
    assign w_wr_data   = (w_cfg.wr_pat == PAT_INV) ? ~BG : BG;
    assign w_mismatch  = w_run && !w_wr_only && w_final && (dout != w_exp);

    // The counter only wraps by reload at an element boundary, never by stepping.
    assign w_load      = ((r_state == S_IDLE || r_state == S_DONE) && start)
                       || (w_run && w_step_end && w_last && !w_mismatch && r_state != S_E5);
    assign w_load_desc = w_run && ELEM_TABLE[w_next_elem].desc;
    assign w_step      = w_run && w_step_end && !w_last && !w_mismatch;

    spr_bist_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_load),
        .i_load_desc(w_load_desc),
        .i_step     (w_step),
        .i_desc     (w_cfg.desc),
        .o_addr     (w_addr),
        .o_last     (w_last)
    );

    assign addr = w_addr;

    // Outputs are set one edge ahead: the values written here are what the RAM sees next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_elem <= '0;
            we        <= 1'b0;
            rd        <= 1'b0;
            din       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    we <= 1'b0;
                    rd <= 1'b0;
                    if (start) begin
                        r_state   <= S_E0;
                        r_phase   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        fail_elem <= '0;
                        we        <= 1'b1;
                        din       <= BG;
                    end
                end
                S_E0: begin
                    if (w_last) begin
                        r_state <= S_E1;
                        we      <= 1'b0;
                        rd      <= 1'b1;
                    end
                end
                default: begin
                    if (!w_final) begin
                        rd      <= 1'b0;
                        r_phase <= r_phase + 2'd1;
                        if ((r_phase + 2'd1 == LAST_PH) && (w_cfg.wr_pat != PAT_NONE)) begin
                            we  <= 1'b1;
                            din <= w_wr_data;
                        end
                    end else begin
                        we      <= 1'b0;
                        r_phase <= '0;
                        if (w_mismatch) begin
                            r_state   <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            fail      <= 1'b1;
                            fail_addr <= w_addr;
                            fail_data <= dout;
                            fail_elem <= w_elem;
                        end else if (w_last && r_state == S_E5) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            rd <= 1'b1;
                            if (w_last) begin
                                r_state <= next_state(r_state);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spr_bist.sv
// Self-checking bench for spr_bist: a march-level model predicts every RAM bus cycle and
// the final verdict, and one compare process checks the selected DUT against it each cycle.
module tb_spr_bist;

    typedef struct packed {
        logic       we;
        logic       rd;
        logic [5:0] addr;
        logic [7:0] din;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0;
    logic       start1;

    logic       busy0, done0, fail0, we0, rd0;
    logic [5:0] faddr0, addr0;
    logic [7:0] fdata0, din0;
    logic [2:0] felem0;
    logic [7:0] dout0;

    logic       busy1, done1, fail1, we1, rd1;
    logic [5:0] faddr1, addr1;
    logic [7:0] fdata1, din1;
    logic [2:0] felem1;
    logic [7:0] dout1;

    always #5 clk = ~clk;

    spr_bist #(.RD_LATENCY(1), .BG(8'h00)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .busy(busy0), .done(done0), .fail(fail0),
        .fail_addr(faddr0), .fail_data(fdata0), .fail_elem(felem0),
        .we(we0), .rd(rd0), .addr(addr0), .din(din0), .dout(dout0)
    );

    spr_bist #(.RD_LATENCY(3), .BG(8'h55)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .busy(busy1), .done(done1), .fail(fail1),
        .fail_addr(faddr1), .fail_data(fdata1), .fail_elem(felem1),
        .we(we1), .rd(rd1), .addr(addr1), .din(din1), .dout(dout1)
    );

    // RAM seen by dut0: one-cycle read latency, with an optional planted fault.
    // faultMode 1 = bit 3 of 0x2A stuck at 1, 2 = write to 0x10 flips bit 0 of 0x11.
    int         faultMode;
    logic [7:0] mem0 [64];

    always @(posedge clk) begin
        if (we0) begin
            mem0[addr0] <= (faultMode == 1 && addr0 == 6'h2A) ? (din0 | 8'h08) : din0;
            if (faultMode == 2 && addr0 == 6'h10) begin
                mem0[6'h11] <= mem0[6'h11] ^ 8'h01;
            end
        end
        if (rd0) begin
            dout0 <= mem0[addr0];
        end
    end

    // RAM seen by dut1: clean, three-cycle read latency through a delay line.
    logic [7:0] mem1 [64];
    logic [7:0] pipeA, pipeB;

    always @(posedge clk) begin
        if (we1) begin
            mem1[addr1] <= din1;
        end
        if (rd1) begin
            pipeA <= mem1[addr1];
        end
        pipeB <= pipeA;
        dout1 <= pipeB;
    end

    // The compare process looks at whichever DUT is currently under test.
    logic       sel;
    wire        sBusy  = sel ? busy1  : busy0;
    wire        sDone  = sel ? done1  : done0;
    wire        sFail  = sel ? fail1  : fail0;
    wire        sWe    = sel ? we1    : we0;
    wire        sRd    = sel ? rd1    : rd0;
    wire [5:0]  sAddr  = sel ? addr1  : addr0;
    wire [7:0]  sDin   = sel ? din1   : din0;
    wire [5:0]  sFaddr = sel ? faddr1 : faddr0;
    wire [7:0]  sFdata = sel ? fdata1 : fdata0;
    wire [2:0]  sFelem = sel ? felem1 : felem0;

    int         total;
    int         bad;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Behavioural model: walks the march elements over an abstract memory carrying the same
    // fault, producing the expected bus activity of every busy cycle and the expected verdict.
    cyc_t       expQ [$];
    logic       expFail;
    logic [5:0] expAddr;
    logic [7:0] expData;
    logic [2:0] expElem;
    int         expLen;
    logic [7:0] mMem [64];

    function automatic cyc_t mk(input logic w, input logic r, input logic [5:0] a, input logic [7:0] d);
        cyc_t c;
        c.we   = w;
        c.rd   = r;
        c.addr = a;
        c.din  = d;
        return c;
    endfunction

    function automatic logic [7:0] modelRead(input int a, input int fault);
        logic [7:0] v;
        v = mMem[a];
        if (fault == 1 && a == 42) v = v | 8'h08;
        return v;
    endfunction

    task automatic modelWrite(input int a, input logic [7:0] d, input int fault);
        mMem[a] = d;
        if (fault == 2 && a == 16) mMem[17] = mMem[17] ^ 8'h01;
    endtask

    task automatic buildModel(input int lat, input logic [7:0] bg, input int fault);
        int         rdSel [6];
        int         wrSel [6];
        bit         down  [6];
        int         a;
        logic [7:0] rp;
        logic [7:0] wp;
        logic [7:0] got;
        rdSel = '{0, 1, 2, 1, 2, 1};
        wrSel = '{1, 2, 1, 2, 1, 0};
        down  = '{0, 0, 0, 1, 1, 0};
        expQ.delete();
        expFail = 1'b0;
        expAddr = '0;
        expData = '0;
        expElem = '0;
        for (int e = 0; e < 6; e++) begin
            rp = (rdSel[e] == 2) ? ~bg : bg;
            wp = (wrSel[e] == 2) ? ~bg : bg;
            for (int i = 0; i < 64; i++) begin
                a = down[e] ? 63 - i : i;
                if (rdSel[e] == 0) begin
                    expQ.push_back(mk(1'b1, 1'b0, 6'(a), wp));
                    modelWrite(a, wp, fault);
                end else begin
                    expQ.push_back(mk(1'b0, 1'b1, 6'(a), 8'h00));
                    for (int w = 1; w < lat; w++) expQ.push_back(mk(1'b0, 1'b0, 6'(a), 8'h00));
                    expQ.push_back(mk(wrSel[e] != 0, 1'b0, 6'(a), wp));
                    got = modelRead(a, fault);
                    if (wrSel[e] != 0) modelWrite(a, wp, fault);
                    if (got != rp) begin
                        expFail = 1'b1;
                        expAddr = 6'(a);
                        expData = got;
                        expElem = 3'(e);
                        expLen  = expQ.size();
                        return;
                    end
                end
            end
        end
        expLen = expQ.size();
    endtask

    logic chkOn;
    logic runDone;
    int   bsyCnt;

    // Per-cycle compare against the model queue; the first cycle after it drains checks the verdict.
    initial begin
        cyc_t e;
        forever begin
            @(negedge clk);
            if (chkOn) begin
                if (sBusy) bsyCnt++;
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("busy", sBusy, 1);
                    checkOutput("doneWhileBusy", sDone, 0);
                    checkOutput("we", sWe, e.we);
                    checkOutput("rd", sRd, e.rd);
                    checkOutput("addr", sAddr, e.addr);
                    if (e.we) checkOutput("din", sDin, e.din);
                end else begin
                    checkOutput("endBusy", sBusy, 0);
                    checkOutput("endDone", sDone, 1);
                    checkOutput("endFail", sFail, expFail);
                    checkOutput("endWe", sWe, 0);
                    checkOutput("endRd", sRd, 0);
                    checkOutput("busyCycles", bsyCnt, expLen);
                    if (expFail) begin
                        checkOutput("failAddr", sFaddr, expAddr);
                        checkOutput("failData", sFdata, expData);
                        checkOutput("failElem", sFelem, expElem);
                    end
                    chkOn   = 1'b0;
                    runDone = 1'b1;
                end
            end
            checkOutput("weRdExcl0", we0 & rd0, 0);
            checkOutput("weRdExcl1", we1 & rd1, 0);
        end
    end

    task automatic setStart(input int which, input logic v);
        if (which == 0) start0 = v;
        else            start1 = v;
    endtask

    // One complete run on DUT 'which'; optional extra start pulse at busy cycle extraAt,
    // plus hand-computed literal expectations for length and verdict.
    task automatic applyStimulus(input int which, input int fault, input int extraAt,
                                 input int litLen, input logic litFail, input logic [5:0] litAddr,
                                 input logic [7:0] litData, input logic [2:0] litElem);
        sel       = (which != 0);
        faultMode = fault;
        buildModel(which != 0 ? 3 : 1, which != 0 ? 8'h55 : 8'h00, fault);
        if (which == 0 && fault == 0) begin
            checkOutput("modelE3FirstRd", expQ[320].rd, 1);
            checkOutput("modelE3FirstAddr", expQ[320].addr, 63);
            checkOutput("modelE0Din", expQ[5].din, 8'h00);
        end
        runDone = 1'b0;
        bsyCnt  = 0;
        @(posedge clk); #1 setStart(which, 1'b1);
        @(posedge clk); #1 setStart(which, 1'b0);
        chkOn = 1'b1;
        for (int c = 0; c < 3000 && !runDone; c++) begin
            @(posedge clk); #1;
            setStart(which, c == extraAt);
        end
        setStart(which, 1'b0);
        checkOutput("runFinished", runDone, 1);
        chkOn = 1'b0;
        checkOutput("litBusyLen", bsyCnt, litLen);
        checkOutput("litFail", sFail, litFail);
        if (litFail) begin
            checkOutput("litFailAddr", sFaddr, litAddr);
            checkOutput("litFailData", sFdata, litData);
            checkOutput("litFailElem", sFelem, litElem);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("idleNoAccess", sWe | sRd, 0);
            checkOutput("idleDone", sDone, 1);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        start0    = 1'b0;
        start1    = 1'b0;
        sel       = 1'b0;
        chkOn     = 1'b0;
        runDone   = 1'b0;
        bsyCnt    = 0;
        faultMode = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        checkOutput("rstBusy", busy0, 0);
        checkOutput("rstDone", done0, 0);
        checkOutput("rstFail", fail0, 0);
        checkOutput("rstWe", we0, 0);
        checkOutput("rstRd", rd0, 0);
        checkOutput("rstAddr", addr0, 0);
        checkOutput("rstDin", din0, 0);
        checkOutput("rstFailAddr", faddr0, 0);
        checkOutput("rstFailData", fdata0, 0);
        checkOutput("rstFailElem", felem0, 0);
        checkOutput("rstBusy1", busy1, 0);

        $display("[TB] clean run, latency 1");
        applyStimulus(0, 0, -1, 704, 1'b0, 6'h00, 8'h00, 3'd0);
        $display("[TB] restart from done, extra start mid-run");
        applyStimulus(0, 0, 300, 704, 1'b0, 6'h00, 8'h00, 3'd0);
        $display("[TB] stuck-at-1 bit 3 at 0x2A");
        applyStimulus(0, 1, -1, 150, 1'b1, 6'h2A, 8'h08, 3'd1);
        $display("[TB] coupling fault 0x10 -> 0x11");
        applyStimulus(0, 2, -1, 100, 1'b1, 6'h11, 8'h01, 3'd1);
        $display("[TB] clean run, latency 3, background 0x55");
        applyStimulus(1, 0, -1, 1344, 1'b0, 6'h00, 8'h00, 3'd0);

        $display("[TB] reset during a run");
        sel       = 1'b0;
        faultMode = 0;
        buildModel(1, 8'h00, 0);
        runDone   = 1'b0;
        bsyCnt    = 0;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        chkOn = 1'b1;
        repeat (399) @(posedge clk);
        #2;
        chkOn = 1'b0;
        expQ.delete();
        checkOutput("preRstBusy", busy0, 1);
        rst = 1'b0;
        #1;
        checkOutput("asyncRstWe", we0, 0);
        checkOutput("asyncRstRd", rd0, 0);
        checkOutput("asyncRstBusy", busy0, 0);
        checkOutput("asyncRstDone", done0, 0);
        checkOutput("asyncRstFail", fail0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("postRstNoAccess", we0 | rd0, 0);
            checkOutput("postRstBusy", busy0, 0);
            checkOutput("postRstDone", done0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
